// File: rtl/bit_serial_adder_pkg.sv
// Shared definitions for the serial arithmetic blocks: state encoding and
// counter sizing. The serial subtractor uses the same encoding so debug
// tooling can decode either block's state the same way.
package bit_serial_adder_pkg;

  // Control states of a serial arithmetic unit.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Bit-step counter width; a 1-bit operand still needs a 1-bit counter.
  function automatic int serial_cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/bit_serial_adder_full_adder_cell.sv
// Single-bit full adder. Purely combinational; the serial adder feeds it one
// operand bit pair per clock together with the registered carry.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial LSB-first adder. Captures a, b and cin on an accepted start,
// then retires one bit per clock through a single full-adder cell and a
// carry flip-flop. Sum bits stream out on ser_sum; the parallel sum and
// final carry are presented on sum/cout with a one-cycle done pulse.
//
// Handshake: start is a request sampled only while busy is low (IDLE); the
// edge that sees start high in IDLE accepts the operands. While busy is high
// (SHIFT or DONE) start is ignored and nothing is queued. ser_sum is valid
// exactly in the cycles where ser_valid is high. done is a one-cycle pulse;
// sum/cout stay stable from that pulse until the next accepted start.
module bit_serial_adder
  import bit_serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             ser_valid,
  output logic             ser_sum,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [1:0]       dbg_state
);

  localparam int             CW       = serial_cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

  state_t           state_q;
  logic [WIDTH-1:0] ra_q, ra_d;
  logic [WIDTH-1:0] rb_q, rb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q;
  logic             ser_valid_q;
  logic             done_q;

  logic             fa_sum;
  logic             fa_cout;

  // The only arithmetic in the block: operand LSBs plus the carry flop.
  full_adder_cell u_fa (
    .a    (ra_q[0]),
    .b    (rb_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Next values for the shift datapath during a bit step.
  always_comb begin
    ra_d  = ra_q >> 1;
    rb_d  = rb_q >> 1;
    cnt_d = cnt_q + CW'(1);
  end

  // Result register fills from the MSB side so that after WIDTH steps the
  // first (LSB) sum bit has landed in bit 0.
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign res_d = fa_sum;
    end else begin : g_res_wn
      assign res_d = {fa_sum, res_q[WIDTH-1:1]};
    end
  endgenerate

  // Control FSM with its registered status outputs and the datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ra_q        <= '0;
      rb_q        <= '0;
      res_q       <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      ser_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // res_q is deliberately left alone: the previous result stays
          // visible until a new operation actually starts shifting.
          if (start) begin
            ra_q        <= a;
            rb_q        <= b;
            carry_q     <= cin;
            cnt_q       <= '0;
            state_q     <= ST_SHIFT;
            busy_q      <= 1'b1;
            ser_valid_q <= 1'b1;
          end
        end
        ST_SHIFT: begin
          ra_q    <= ra_d;
          rb_q    <= rb_d;
          res_q   <= res_d;
          carry_q <= fa_cout;
          cnt_q   <= cnt_d;
          if (cnt_q == LAST_CNT) begin
            state_q     <= ST_DONE;
            ser_valid_q <= 1'b0;
            done_q      <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q     <= ST_IDLE;
          busy_q      <= 1'b0;
          ser_valid_q <= 1'b0;
          done_q      <= 1'b0;
        end
      endcase
    end
  end

  // ser_sum is the live full-adder output, gated to zero outside SHIFT.
  assign ser_sum   = ser_valid_q & fa_sum;
  assign busy      = busy_q;
  assign ser_valid = ser_valid_q;
  assign done      = done_q;
  assign sum       = res_q;
  assign cout      = carry_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed bench for bit_serial_adder: an 8-bit instance for the main
// scenarios and a 1-bit instance for the full-adder truth table.
module tb_bit_serial_adder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 8-bit instance
  logic       start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       cin = 1'b0;
  logic       busy, ser_valid, ser_sum, done, cout;
  logic [7:0] sum;
  logic [1:0] dbg_state;

  // 1-bit instance
  logic       start1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       cin1 = 1'b0;
  logic       busy1, ser_valid1, ser_sum1, done1, cout1;
  logic [0:0] sum1;
  logic [1:0] dbg_state1;

  int n_pass  = 0;
  int n_total = 0;

  bit_serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .ser_valid(ser_valid), .ser_sum(ser_sum), .done(done),
    .sum(sum), .cout(cout), .dbg_state(dbg_state)
  );

  bit_serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .ser_valid(ser_valid1), .ser_sum(ser_sum1), .done(done1),
    .sum(sum1), .cout(cout1), .dbg_state(dbg_state1)
  );

  // Watchdog: every loop below is bounded, this only guards against a stuck sim.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver ----------------
  // Runs one 8-bit operation from IDLE. Edge 0 is the accept edge. Observes
  // outputs #1 after each edge 0..11. Optionally re-pulses start with other
  // operands so that it is sampled on edge inj_edge.
  task automatic do_op8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                        input int inj_edge, input logic [7:0] av2, input logic [7:0] bv2,
                        output logic [7:0] ser, output int n_ser, output int done_edge,
                        output int n_done, output int n_busy);
    ser = '0; n_ser = 0; done_edge = -1; n_done = 0; n_busy = 0;
    start = 1'b1; a = av; b = bv; cin = cv;
    @(posedge clk); #1;
    start = 1'b0; a = ~av; b = ~bv; cin = ~cv;   // post-accept changes must not matter
    for (int e = 0; e < 12; e++) begin
      if (ser_valid) begin
        if (n_ser < 8) ser[n_ser] = ser_sum;
        n_ser++;
      end
      if (done) begin
        n_done++;
        if (done_edge < 0) done_edge = e;
      end
      if (busy) n_busy++;
      if (e + 1 == inj_edge) begin
        start = 1'b1; a = av2; b = bv2; cin = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_total++; if (busy !== 1'b0)       $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
    n_total++; if (ser_valid !== 1'b0)  $display("FAIL reset_ser_valid: got %b expected 0", ser_valid); else n_pass++;
    n_total++; if (ser_sum !== 1'b0)    $display("FAIL reset_ser_sum: got %b expected 0", ser_sum); else n_pass++;
    n_total++; if (done !== 1'b0)       $display("FAIL reset_done: got %b expected 0", done); else n_pass++;
    n_total++; if (sum !== 8'h00)       $display("FAIL reset_sum: got %h expected 00", sum); else n_pass++;
    n_total++; if (cout !== 1'b0)       $display("FAIL reset_cout: got %b expected 0", cout); else n_pass++;
    n_total++; if (dbg_state !== 2'd0)  $display("FAIL reset_state: got %0d expected 0", dbg_state); else n_pass++;
    n_total++; if (busy1 !== 1'b0)      $display("FAIL reset_busy_w1: got %b expected 0", busy1); else n_pass++;
    n_total++; if (dbg_state1 !== 2'd0) $display("FAIL reset_state_w1: got %0d expected 0", dbg_state1); else n_pass++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [7:0] ser; int n_ser, de, nd, nb;
    // 0x5A + 0x33 = 0x8D, streamed LSB first as 1,0,1,1,0,0,0,1
    do_op8(8'h5A, 8'h33, 1'b0, -1, 8'h00, 8'h00, ser, n_ser, de, nd, nb);
    n_total++; if (ser !== 8'h8D)  $display("FAIL basic_ser_bits: got %h expected 8d", ser); else n_pass++;
    n_total++; if (n_ser !== 8)    $display("FAIL basic_ser_count: got %0d expected 8", n_ser); else n_pass++;
    n_total++; if (de !== 8)       $display("FAIL basic_done_edge: got %0d expected 8", de); else n_pass++;
    n_total++; if (nd !== 1)       $display("FAIL basic_done_pulses: got %0d expected 1", nd); else n_pass++;
    n_total++; if (nb !== 9)       $display("FAIL basic_busy_cycles: got %0d expected 9", nb); else n_pass++;
    n_total++; if (sum !== 8'h8D)  $display("FAIL basic_sum: got %h expected 8d", sum); else n_pass++;
    n_total++; if (cout !== 1'b0)  $display("FAIL basic_cout: got %b expected 0", cout); else n_pass++;
    n_total++; if (dbg_state !== 2'd0) $display("FAIL basic_idle: got %0d expected 0", dbg_state); else n_pass++;
  endtask

  task automatic test_wrap();
    logic [7:0] ser; int n_ser, de, nd, nb;
    // 0xFF + 0x01 + 0 = 0x100
    do_op8(8'hFF, 8'h01, 1'b0, -1, 8'h00, 8'h00, ser, n_ser, de, nd, nb);
    n_total++; if (sum !== 8'h00)  $display("FAIL wrap1_sum: got %h expected 00", sum); else n_pass++;
    n_total++; if (cout !== 1'b1)  $display("FAIL wrap1_cout: got %b expected 1", cout); else n_pass++;
    n_total++; if (ser !== 8'h00)  $display("FAIL wrap1_ser_bits: got %h expected 00", ser); else n_pass++;
    // 0xFF + 0xFF + 1 = 0x1FF
    do_op8(8'hFF, 8'hFF, 1'b1, -1, 8'h00, 8'h00, ser, n_ser, de, nd, nb);
    n_total++; if (sum !== 8'hFF)  $display("FAIL wrap2_sum: got %h expected ff", sum); else n_pass++;
    n_total++; if (cout !== 1'b1)  $display("FAIL wrap2_cout: got %b expected 1", cout); else n_pass++;
    n_total++; if (ser !== 8'hFF)  $display("FAIL wrap2_ser_bits: got %h expected ff", ser); else n_pass++;
  endtask

  task automatic test_start_while_busy();
    logic [7:0] ser; int n_ser, de, nd, nb;
    // 0x12 + 0x34 + 1 = 0x47; a second start on edge 3 with other operands is ignored
    do_op8(8'h12, 8'h34, 1'b1, 3, 8'hF0, 8'hF0, ser, n_ser, de, nd, nb);
    n_total++; if (sum !== 8'h47)  $display("FAIL busy_start_sum: got %h expected 47", sum); else n_pass++;
    n_total++; if (cout !== 1'b0)  $display("FAIL busy_start_cout: got %b expected 0", cout); else n_pass++;
    n_total++; if (nd !== 1)       $display("FAIL busy_start_done_pulses: got %0d expected 1", nd); else n_pass++;
    n_total++; if (de !== 8)       $display("FAIL busy_start_done_edge: got %0d expected 8", de); else n_pass++;
  endtask

  task automatic test_reset_mid_op();
    logic [7:0] ser; int n_ser, de, nd, nb; int seen;
    start = 1'b1; a = 8'h5A; b = 8'h33; cin = 1'b0;
    @(posedge clk); #1;                  // edge 0: accept
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end   // edges 1..3
    rst = 1'b1;
    @(posedge clk); #1;                  // edge 4: reset sampled
    rst = 1'b0;
    n_total++; if (busy !== 1'b0)      $display("FAIL midrst_busy: got %b expected 0", busy); else n_pass++;
    n_total++; if (ser_valid !== 1'b0) $display("FAIL midrst_ser_valid: got %b expected 0", ser_valid); else n_pass++;
    n_total++; if (ser_sum !== 1'b0)   $display("FAIL midrst_ser_sum: got %b expected 0", ser_sum); else n_pass++;
    n_total++; if (done !== 1'b0)      $display("FAIL midrst_done: got %b expected 0", done); else n_pass++;
    n_total++; if (sum !== 8'h00)      $display("FAIL midrst_sum: got %h expected 00", sum); else n_pass++;
    n_total++; if (cout !== 1'b0)      $display("FAIL midrst_cout: got %b expected 0", cout); else n_pass++;
    n_total++; if (dbg_state !== 2'd0) $display("FAIL midrst_state: got %0d expected 0", dbg_state); else n_pass++;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    n_total++; if (seen !== 0) $display("FAIL midrst_no_activity: got %0d active cycles expected 0", seen); else n_pass++;
    // 0x80 + 0x80 + 1 = 0x101
    do_op8(8'h80, 8'h80, 1'b1, -1, 8'h00, 8'h00, ser, n_ser, de, nd, nb);
    n_total++; if (sum !== 8'h01)  $display("FAIL midrst_after_sum: got %h expected 01", sum); else n_pass++;
    n_total++; if (cout !== 1'b1)  $display("FAIL midrst_after_cout: got %b expected 1", cout); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] av [4];
    logic [7:0] bv [4];
    logic       cv [4];
    logic [8:0] exp_q[$];
    logic [8:0] exp;
    int nxt, n_done;
    av = '{8'h01, 8'hC8, 8'h7F, 8'hAA};
    bv = '{8'h02, 8'h64, 8'h80, 8'h55};
    cv = '{1'b0,  1'b1,  1'b1,  1'b1};
    // reference a+b+cin as a 9-bit {cout,sum}
    start = 1'b1; a = av[0]; b = bv[0]; cin = cv[0];
    exp_q.push_back({1'b0, av[0]} + {1'b0, bv[0]} + {8'h00, cv[0]});
    nxt = 1; n_done = 0;
    @(posedge clk); #1;                  // edge 0: first accept
    for (int t = 0; t < 45; t++) begin
      if (done) begin
        n_done++;
        n_total++; if (t % 10 !== 8) $display("FAIL b2b_done_edge: got %0d expected 8 mod 10", t); else n_pass++;
        if (exp_q.size() == 0) begin
          n_total++; $display("FAIL b2b_unexpected_done: got done at edge %0d expected none", t);
        end else begin
          exp = exp_q.pop_front();
          n_total++; if (sum !== exp[7:0]) $display("FAIL b2b_sum: got %h expected %h", sum, exp[7:0]); else n_pass++;
          n_total++; if (cout !== exp[8])  $display("FAIL b2b_cout: got %b expected %b", cout, exp[8]); else n_pass++;
        end
      end
      // start stays high; operands for the next accept are set early in each op
      if (t % 10 == 1) begin
        if (nxt < 4) begin
          a = av[nxt]; b = bv[nxt]; cin = cv[nxt];
          exp_q.push_back({1'b0, av[nxt]} + {1'b0, bv[nxt]} + {8'h00, cv[nxt]});
          nxt++;
        end else begin
          start = 1'b0;
        end
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    n_total++; if (n_done !== 4)       $display("FAIL b2b_done_count: got %0d expected 4", n_done); else n_pass++;
    n_total++; if (exp_q.size() !== 0) $display("FAIL b2b_leftover: got %0d pending expected 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_width1();
    logic [7:0] sum_tbl, cout_tbl;
    logic [2:0] idx;
    sum_tbl  = 8'b1001_0110;   // a^b^c indexed by {a,b,c}
    cout_tbl = 8'b1110_1000;   // majority indexed by {a,b,c}
    for (int i = 0; i < 8; i++) begin
      idx = 3'(i);
      start1 = 1'b1; a1 = idx[2]; b1 = idx[1]; cin1 = idx[0];
      @(posedge clk); #1;                // edge 0: accept, now in SHIFT
      start1 = 1'b0;
      n_total++; if (ser_sum1 !== sum_tbl[idx]) $display("FAIL w1_ser_sum[%0d]: got %b expected %b", i, ser_sum1, sum_tbl[idx]); else n_pass++;
      @(posedge clk); #1;                // edge 1: single step, now in DONE
      n_total++; if (done1 !== 1'b1)             $display("FAIL w1_done[%0d]: got %b expected 1", i, done1); else n_pass++;
      n_total++; if (sum1[0] !== sum_tbl[idx])   $display("FAIL w1_sum[%0d]: got %b expected %b", i, sum1[0], sum_tbl[idx]); else n_pass++;
      n_total++; if (cout1 !== cout_tbl[idx])    $display("FAIL w1_cout[%0d]: got %b expected %b", i, cout1, cout_tbl[idx]); else n_pass++;
      @(posedge clk); #1;                // edge 2: back in IDLE
      n_total++; if (dbg_state1 !== 2'd0)        $display("FAIL w1_idle[%0d]: got %0d expected 0", i, dbg_state1); else n_pass++;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_start_while_busy();
    test_reset_mid_op();
    test_back_to_back();
    test_width1();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
